biquad_coeff_loader: RTL and testbench

- Receives coefficient frames as a byte stream from the host/MCU link and decodes them.
- Validates each frame and commits the five coefficients of one biquad stage atomically to that stage's coefficient outputs.
- Pulses the stage's modeReset input so its filter state is flushed whenever its coefficients change.
- Sits between the control-link byte receiver and the NUM_STAGES biquad1 instances of the filter chain.

---
 rtl/biquad_coeff_loader.sv | 194 +++++++++++++++++++
 tb/tb_biquad_coeff_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/biquad_coeff_loader.sv
// biquad_coeff_loader
// Decodes 18-byte coefficient frames (A5, stage, 15 payload bytes, XOR checksum)
// from the control-link byte stream and commits the five Q2.16 coefficients of
// one biquad stage atomically, pulsing that stage's modeReset for HOLD_CYCLES.
//
// Byte handshake: rxValid_i is a one-cycle strobe with no back-pressure; a byte
// is consumed on every rising clk_i edge where rxValid_i is high.
module biquad_coeff_loader #(
  parameter int NUM_STAGES     = 4,
  parameter int COEFF_WIDTH    = 18,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [7:0]                          rxData_i,
  input  logic                                rxValid_i,
  output logic [NUM_STAGES*COEFF_WIDTH-1:0]   b0_o,
  output logic [NUM_STAGES*COEFF_WIDTH-1:0]   b1_o,
  output logic [NUM_STAGES*COEFF_WIDTH-1:0]   b2_o,
  output logic [NUM_STAGES*COEFF_WIDTH-1:0]   NEGa1_o,
  output logic [NUM_STAGES*COEFF_WIDTH-1:0]   NEGa2_o,
  output logic [NUM_STAGES-1:0]               modeReset_o,
  output logic                                frameOk_o,
  output logic                                frameErr_o,
  output logic                                busy_o
);

  localparam logic [7:0] HEADER = 8'hA5;
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, STAGE, PAYLOAD, CHECK} state_e;

  state_e       state_q, state_d;
  logic [7:0]   stage_q;
  logic [7:0]   xor_q;
  logic [3:0]   byte_cnt_q;
  logic [119:0] staging_q;
  logic [GW-1:0] gap_q;

  logic [COEFF_WIDTH-1:0] b0_q   [NUM_STAGES];
  logic [COEFF_WIDTH-1:0] b1_q   [NUM_STAGES];
  logic [COEFF_WIDTH-1:0] b2_q   [NUM_STAGES];
  logic [COEFF_WIDTH-1:0] a1_q   [NUM_STAGES];
  logic [COEFF_WIDTH-1:0] a2_q   [NUM_STAGES];
  logic [HW-1:0]          hold_q [NUM_STAGES];

  logic take_stage, take_payload, commit, reject, timeout, stage_ok;
  logic frame_ok_q, frame_err_q;

  // Each 24-bit payload word keeps only its low COEFF_WIDTH bits.
  logic [COEFF_WIDTH-1:0] new_b0, new_b1, new_b2, new_a1, new_a2;
  assign new_b0 = staging_q[96 +: COEFF_WIDTH];
  assign new_b1 = staging_q[72 +: COEFF_WIDTH];
  assign new_b2 = staging_q[48 +: COEFF_WIDTH];
  assign new_a1 = staging_q[24 +: COEFF_WIDTH];
  assign new_a2 = staging_q[0  +: COEFF_WIDTH];

  // Upper bits of each payload word are deliberately dropped.
  logic unused_staging;
  assign unused_staging = ^staging_q;

  assign stage_ok = (int'(stage_q) < NUM_STAGES);
  // The timeout only fires on a cycle with no incoming byte.
  assign timeout  = (state_q != IDLE) && !rxValid_i &&
                    (gap_q == GW'(TIMEOUT_CYCLES - 1));

  // FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state and per-cycle datapath controls.
  always_comb begin
    state_d      = state_q;
    take_stage   = 1'b0;
    take_payload = 1'b0;
    commit       = 1'b0;
    reject       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxValid_i && rxData_i == HEADER) state_d = STAGE;
      end
      STAGE: begin
        if (rxValid_i) begin
          take_stage = 1'b1;
          state_d    = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (rxValid_i) begin
          take_payload = 1'b1;
          if (byte_cnt_q == 4'd14) state_d = CHECK;
        end
      end
      CHECK: begin
        if (rxValid_i) begin
          state_d = IDLE;
          if (rxData_i == xor_q && stage_ok) commit = 1'b1;
          else                               reject = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = IDLE;
      reject  = 1'b1;
    end
  end

  // Frame assembly: stage latch, running checksum, payload shift, gap timer.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stage_q    <= '0;
      xor_q      <= '0;
      byte_cnt_q <= '0;
      staging_q  <= '0;
      gap_q      <= '0;
    end else begin
      if (take_stage) begin
        stage_q    <= rxData_i;
        xor_q      <= rxData_i;
        byte_cnt_q <= '0;
      end
      if (take_payload) begin
        staging_q  <= {staging_q[111:0], rxData_i};
        xor_q      <= xor_q ^ rxData_i;
        byte_cnt_q <= byte_cnt_q + 4'd1;
      end
      if (timeout) staging_q <= '0;
      if (state_q == IDLE || rxValid_i || timeout) gap_q <= '0;
      else                                         gap_q <= gap_q + GW'(1);
    end
  end

  // Coefficient banks and per-stage modeReset hold counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        b0_q[s]   <= '0;
        b1_q[s]   <= '0;
        b2_q[s]   <= '0;
        a1_q[s]   <= '0;
        a2_q[s]   <= '0;
        hold_q[s] <= HW'(HOLD_CYCLES);
      end
    end else begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (commit && stage_q == 8'(s)) begin
          b0_q[s]   <= new_b0;
          b1_q[s]   <= new_b1;
          b2_q[s]   <= new_b2;
          a1_q[s]   <= new_a1;
          a2_q[s]   <= new_a2;
          hold_q[s] <= HW'(HOLD_CYCLES);
        end else if (hold_q[s] != '0) begin
          hold_q[s] <= hold_q[s] - HW'(1);
        end
      end
    end
  end

  // Status pulses, registered so they align with the committed outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_ok_q  <= commit;
      frame_err_q <= reject;
    end
  end

  // modeReset is high while the stage's hold counter is running.
  always_comb begin
    modeReset_o = '0;
    for (int s = 0; s < NUM_STAGES; s++) modeReset_o[s] = (hold_q[s] != '0);
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_pack
    assign b0_o[s*COEFF_WIDTH +: COEFF_WIDTH]    = b0_q[s];
    assign b1_o[s*COEFF_WIDTH +: COEFF_WIDTH]    = b1_q[s];
    assign b2_o[s*COEFF_WIDTH +: COEFF_WIDTH]    = b2_q[s];
    assign NEGa1_o[s*COEFF_WIDTH +: COEFF_WIDTH] = a1_q[s];
    assign NEGa2_o[s*COEFF_WIDTH +: COEFF_WIDTH] = a2_q[s];
  end

  assign frameOk_o  = frame_ok_q;
  assign frameErr_o = frame_err_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Testbench for biquad_coeff_loader: directed frames, expected-event queue,
// cycle-by-cycle monitor of coefficients and modeReset.
module tb_biquad_coeff_loader;

  localparam int NS   = 4;
  localparam int CW   = 18;
  localparam int HOLD = 8;
  localparam int TO   = 1024;
  localparam int EW   = 1 + 8 + 5*CW;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic reset_i;
  logic [7:0] rxData_i;
  logic rxValid_i;
  logic [NS*CW-1:0] b0_o, b1_o, b2_o, NEGa1_o, NEGa2_o;
  logic [NS-1:0] modeReset_o;
  logic frameOk_o, frameErr_o, busy_o;

  always #5 clk_i = ~clk_i;

  biquad_coeff_loader #(
    .NUM_STAGES(NS), .COEFF_WIDTH(CW), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .rxData_i(rxData_i), .rxValid_i(rxValid_i),
    .b0_o(b0_o), .b1_o(b1_o), .b2_o(b2_o), .NEGa1_o(NEGa1_o), .NEGa2_o(NEGa2_o),
    .modeReset_o(modeReset_o), .frameOk_o(frameOk_o), .frameErr_o(frameErr_o),
    .busy_o(busy_o)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int commit_pend;
  logic [CW-1:0] m_c [5][NS];
  int hold_m [NS];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxData_i  = b;
    rxValid_i = 1'b1;
    @(posedge clk_i);
    #1;
    rxValid_i = 1'b0;
    rxData_i  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] stg,
                            input logic [23:0] c0, input logic [23:0] c1,
                            input logic [23:0] c2, input logic [23:0] c3,
                            input logic [23:0] c4, input logic corrupt);
    logic [119:0] pl;
    logic [7:0]   cks;
    logic         ok;
    pl  = {c0, c1, c2, c3, c4};
    cks = stg;
    for (int i = 0; i < 15; i++) cks = cks ^ pl[119-8*i -: 8];
    if (corrupt) cks = cks ^ 8'h01;
    ok = !corrupt && (int'(stg) < NS);
    exp_q.push_back({ok, stg, c0[CW-1:0], c1[CW-1:0], c2[CW-1:0], c3[CW-1:0], c4[CW-1:0]});
    send_byte(8'hA5);
    send_byte(stg);
    for (int i = 0; i < 15; i++) send_byte(pl[119-8*i -: 8]);
    if (ok) commit_pend = int'(stg);
    send_byte(cks);
    commit_pend = -1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    int cp;
    logic [EW-1:0] e;
    logic [NS-1:0] exp_mr;
    logic [NS*CW-1:0] ev;
    for (int s = 0; s < NS; s++) begin
      hold_m[s] = HOLD;
      for (int k = 0; k < 5; k++) m_c[k][s] = '0;
    end
    forever begin
      @(posedge clk_i);
      cp = commit_pend;
      for (int s = 0; s < NS; s++) begin
        if (reset_i) begin
          hold_m[s] = HOLD;
          for (int k = 0; k < 5; k++) m_c[k][s] = '0;
        end else if (s == cp) hold_m[s] = HOLD;
        else if (hold_m[s] > 0) hold_m[s]--;
      end
      #1;
      for (int s = 0; s < NS; s++) exp_mr[s] = (hold_m[s] > 0);
      check("mode_reset", 128'(modeReset_o), 128'(exp_mr));
      if (frameOk_o && frameErr_o) check("ok_err_exclusive", 128'(1), 128'(0));
      if (frameOk_o || frameErr_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {126'(0), frameOk_o, frameErr_o}, 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("frame_result_ok", 128'(frameOk_o), 128'(e[EW-1]));
          check("frame_result_err", 128'(frameErr_o), 128'(!e[EW-1]));
          if (e[EW-1] && int'(e[EW-2 -: 8]) < NS) begin
            for (int k = 0; k < 5; k++)
              m_c[k][e[EW-2 -: 8]] = e[(4-k)*CW +: CW];
          end
        end
      end
      for (int k = 0; k < 5; k++) begin
        for (int s = 0; s < NS; s++) ev[s*CW +: CW] = m_c[k][s];
        case (k)
          0: check("b0", 128'(b0_o), 128'(ev));
          1: check("b1", 128'(b1_o), 128'(ev));
          2: check("b2", 128'(b2_o), 128'(ev));
          3: check("nega1", 128'(NEGa1_o), 128'(ev));
          default: check("nega2", 128'(NEGa2_o), 128'(ev));
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_i     = 1'b1;
    rxValid_i   = 1'b0;
    rxData_i    = 8'h00;
    commit_pend = -1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_mode_reset", 128'(modeReset_o), 128'(4'hF));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_ok", 128'(frameOk_o), 128'(0));
    check("rst_err", 128'(frameErr_o), 128'(0));
    check("rst_b0", 128'(b0_o), 128'(0));
    reset_i = 1'b0;
    idle(7);
    check("hold_after_release_7", 128'(modeReset_o), 128'(4'hF));
    idle(1);
    check("hold_after_release_8", 128'(modeReset_o), 128'(4'h0));
    idle(4);

    // Unity b0 on stage 1.
    send_frame(8'h01, 24'h010000, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0);
    idle(12);
    // Same frame, bad checksum.
    send_frame(8'h01, 24'h010000, 24'h0, 24'h0, 24'h0, 24'h0, 1'b1);
    idle(4);
    // Out-of-range stage with a correct checksum.
    send_frame(8'h07, 24'h010000, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0);
    idle(4);

    // Truncated frame, then timeout.
    exp_q.push_back({1'b0, 8'h02, {(5*CW){1'b0}}});
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    idle(TO - 1);
    check("busy_before_timeout", 128'(busy_o), 128'(1));
    idle(1);
    check("busy_after_timeout", 128'(busy_o), 128'(0));
    check("err_at_timeout", 128'(frameErr_o), 128'(1));
    idle(3);
    send_frame(8'h02, 24'h000100, 24'hABCDEF, 24'h000002, 24'h00FFFF, 24'hFFFFF0, 1'b0);
    idle(3);
    check("stage2_nega2", 128'(NEGa2_o[2*CW +: CW]), 128'(18'h3FFF0));

    // Back-to-back frames to stage 3 (header 0xA5 also appears as data).
    send_frame(8'h03, 24'h000001, 24'h0000A5, 24'h000003, 24'h000004, 24'h000005, 1'b0);
    send_frame(8'h03, 24'h00A5A5, 24'h020000, 24'h030000, 24'h012345, 24'h3FFFFF, 1'b0);
    idle(12);

    // Noise before a frame is ignored.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    idle(2);
    check("noise_busy", 128'(busy_o), 128'(0));
    send_frame(8'h00, 24'h123456, 24'h7FFFFF, 24'h800000, 24'h000000, 24'hFEDCBA, 1'b0);
    idle(12);
    check("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
